// File: rtl/rst_sequencer.sv
// rst_sequencer
//   Filters the PLL lock, stretches reset after lock, then releases
//   N_STAGES reset outputs one after another with a programmable gap.
//   Also handles a soft-reset request from RUN, drops back to the start on
//   lock loss, and keeps a saturating count of lock losses.
//
// Ports
//   clk_in         system clock (PLL output)
//   rst_in_n       asynchronous active-low reset; asserts rst_out at once
//   pll_lock       raw PLL lock, synchronised internally by two flops
//   soft_rst_req   synchronous soft-reset request, honoured in RUN only
//   rst_out        active-high stage resets, bit 0 is released first
//   ready          high only while every stage is released
//   lock_loss_cnt  saturating count of lock losses after the filter passed
//   state          FSM code: 0 WAIT_LOCK, 1 FILTER, 2 HOLD, 3 RELEASE, 4 RUN
module rst_sequencer #(
    parameter int N_STAGES    = 2,
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_CYCLES = 128,
    parameter int STAGE_GAP   = 64,
    parameter int SOFT_HOLD   = 32,
    parameter int CNT_W       = 8
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    input  logic                pll_lock,
    input  logic                soft_rst_req,
    output logic [N_STAGES-1:0] rst_out,
    output logic                ready,
    output logic [CNT_W-1:0]    lock_loss_cnt,
    output logic [2:0]          state
);

    localparam int MAX_AB  = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
    localparam int MAX_CD  = (STAGE_GAP > SOFT_HOLD) ? STAGE_GAP : SOFT_HOLD;
    localparam int MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_LEN) + 1;

    localparam logic [CW-1:0] FILTER_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SOFT_LAST   = CW'(SOFT_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);

    // Stages are released by shifting zeros in from bit 0; when only the
    // top bit is still set, the next release is the final one.
    localparam logic [N_STAGES-1:0] ALL_ONES   = '1;
    localparam logic [N_STAGES-1:0] LAST_STAGE = ~(ALL_ONES >> 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        FILTER    = 3'd1,
        HOLD      = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t          fsm;
    logic            lock_p0;
    logic            lock_p1;
    logic            lock_s;
    logic [CW-1:0]   cnt;
    logic            soft_hold;
    logic            armed;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign lock_s = lock_p1;
    assign state  = fsm;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            lock_p0       <= 1'b0;
            lock_p1       <= 1'b0;
            fsm           <= WAIT_LOCK;
            cnt           <= '0;
            soft_hold     <= 1'b0;
            armed         <= 1'b1;
            rst_out       <= '1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            // lock synchroniser: lock_p0 -> lock_p1
            lock_p0 <= pll_lock;
            lock_p1 <= lock_p0;

            // A held request fires once; it must be seen low before it can
            // fire again.
            if (!soft_rst_req) armed <= 1'b1;

            // sequencer FSM
            case (fsm)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        fsm <= FILTER;
                        cnt <= '0;
                    end
                end

                FILTER: begin
                    if (!lock_s) begin
                        fsm <= WAIT_LOCK;
                        cnt <= '0;
                    end else if (cnt == FILTER_LAST) begin
                        fsm       <= HOLD;
                        cnt       <= '0;
                        soft_hold <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                HOLD, RELEASE: begin
                    if (!lock_s) begin
                        rst_out       <= '1;
                        ready         <= 1'b0;
                        fsm           <= WAIT_LOCK;
                        cnt           <= '0;
                        lock_loss_cnt <= sat_inc(lock_loss_cnt);
                    end else if ((fsm == HOLD    && cnt == (soft_hold ? SOFT_LAST : HOLD_LAST)) ||
                                 (fsm == RELEASE && cnt == GAP_LAST)) begin
                        rst_out <= rst_out << 1;
                        cnt     <= '0;
                        if (rst_out == LAST_STAGE) begin
                            fsm   <= RUN;
                            ready <= 1'b1;
                        end else begin
                            fsm <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RUN: begin
                    // Lock loss outranks a soft request on the same edge.
                    if (!lock_s) begin
                        rst_out       <= '1;
                        ready         <= 1'b0;
                        fsm           <= WAIT_LOCK;
                        cnt           <= '0;
                        lock_loss_cnt <= sat_inc(lock_loss_cnt);
                    end else if (soft_rst_req && armed) begin
                        rst_out   <= '1;
                        ready     <= 1'b0;
                        fsm       <= HOLD;
                        cnt       <= '0;
                        soft_hold <= 1'b1;
                        armed     <= 1'b0;
                    end
                end

                default: begin
                    rst_out <= '1;
                    ready   <= 1'b0;
                    fsm     <= WAIT_LOCK;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer
//   Directed bench for rst_sequencer with default timing and a 2-bit
//   lock-loss counter. Expected snapshots are queued with the edge number
//   at which they must appear and compared 1 time unit after that edge.
module tb_rst_sequencer;

    logic       clk_in = 1'b0;
    logic       rst_in_n;
    logic       pll_lock;
    logic       soft_rst_req;
    logic [1:0] rst_out;
    logic       ready;
    logic [1:0] lock_loss_cnt;
    logic [2:0] state;

    rst_sequencer #(
        .N_STAGES   (2),
        .LOCK_FILTER(16),
        .HOLD_CYCLES(128),
        .STAGE_GAP  (64),
        .SOFT_HOLD  (32),
        .CNT_W      (2)
    ) dut (
        .clk_in       (clk_in),
        .rst_in_n     (rst_in_n),
        .pll_lock     (pll_lock),
        .soft_rst_req (soft_rst_req),
        .rst_out      (rst_out),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt),
        .state        (state)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         at;
        string      tag;
        logic [1:0] r;
        logic       d;
        logic [1:0] c;
        logic [2:0] s;
    } exp_t;

    exp_t sb[$];
    int   edge_n;
    int   checks;
    int   errors;

    task automatic check_now(input string tag, input logic [1:0] r, input logic d,
                             input logic [1:0] c, input logic [2:0] s);
        checks++;
        assert ({rst_out, ready, lock_loss_cnt, state} === {r, d, c, s})
        else begin
            errors++;
            $error("FAIL %s edge %0d: observed rst_out=%b ready=%b cnt=%0d state=%0d expected rst_out=%b ready=%b cnt=%0d state=%0d",
                   tag, edge_n, rst_out, ready, lock_loss_cnt, state, r, d, c, s);
        end
    endtask

    task automatic expect_at(input int at, input string tag, input logic [1:0] r,
                             input logic d, input logic [1:0] c, input logic [2:0] s);
        exp_t e;
        e.at = at; e.tag = tag; e.r = r; e.d = d; e.c = c; e.s = s;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk_in);
        #1;
        edge_n++;
        while (sb.size() > 0 && sb[0].at <= edge_n) begin
            e = sb.pop_front();
            if (e.at == edge_n) begin
                check_now(e.tag, e.r, e.d, e.c, e.s);
            end else begin
                checks++;
                errors++;
                $error("FAIL %s: expectation for edge %0d reached only at edge %0d", e.tag, e.at, edge_n);
            end
        end
    endtask

    task automatic run_to(input int t);
        while (edge_n < t) step();
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (sb.size() > 0 && guard < 2000) begin
            step();
            guard++;
        end
        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL %s: %0d expectations still pending after %0d cycles, required 0", tag, sb.size(), guard);
            sb.delete();
        end
    endtask

    // Assert reset between edges, check the asynchronous effect, then release
    // with lock high so that the next edge is edge 1 with lock sampled high.
    task automatic apply_reset(input string tag);
        rst_in_n     = 1'b0;
        pll_lock     = 1'b0;
        soft_rst_req = 1'b0;
        #1;
        check_now(tag, 2'b11, 1'b0, 2'd0, 3'd0);
        step();
        step();
        check_now({tag, "_held"}, 2'b11, 1'b0, 2'd0, 3'd0);
        rst_in_n = 1'b1;
        pll_lock = 1'b1;
        edge_n   = 0;
    endtask

    initial begin
        int         b;
        logic [1:0] cur;
        logic [1:0] nxt;

        checks       = 0;
        errors       = 0;
        edge_n       = 0;
        rst_in_n     = 1'b1;
        pll_lock     = 1'b0;
        soft_rst_req = 1'b0;
        #1;

        // Power-on reset and cold start
        apply_reset("por");
        expect_at(2,   "cs_wait",   2'b11, 1'b0, 2'd0, 3'd0);
        expect_at(3,   "cs_filter", 2'b11, 1'b0, 2'd0, 3'd1);
        expect_at(18,  "cs_flast",  2'b11, 1'b0, 2'd0, 3'd1);
        expect_at(19,  "cs_hold",   2'b11, 1'b0, 2'd0, 3'd2);
        expect_at(146, "cs_hlast",  2'b11, 1'b0, 2'd0, 3'd2);
        expect_at(147, "cs_rst0",   2'b10, 1'b0, 2'd0, 3'd3);
        expect_at(210, "cs_glast",  2'b10, 1'b0, 2'd0, 3'd3);
        expect_at(211, "cs_run",    2'b00, 1'b1, 2'd0, 3'd4);
        drain("cold_start");

        // Lock glitch in FILTER at count 10, reset taken from RUN
        apply_reset("rst_run");
        expect_at(13,  "gl_cnt10",  2'b11, 1'b0, 2'd0, 3'd1);
        run_to(11);
        pll_lock = 1'b0;
        run_to(12);
        pll_lock = 1'b1;
        expect_at(14,  "gl_wait",   2'b11, 1'b0, 2'd0, 3'd0);
        expect_at(15,  "gl_filter", 2'b11, 1'b0, 2'd0, 3'd1);
        expect_at(30,  "gl_flast",  2'b11, 1'b0, 2'd0, 3'd1);
        expect_at(31,  "gl_hold",   2'b11, 1'b0, 2'd0, 3'd2);
        expect_at(158, "gl_hlast",  2'b11, 1'b0, 2'd0, 3'd2);
        expect_at(159, "gl_rst0",   2'b10, 1'b0, 2'd0, 3'd3);
        expect_at(222, "gl_glast",  2'b10, 1'b0, 2'd0, 3'd3);
        expect_at(223, "gl_run",    2'b00, 1'b1, 2'd0, 3'd4);
        drain("glitch");

        // Lock loss in RUN, sampled low at edge 230
        run_to(229);
        pll_lock = 1'b0;
        expect_at(231, "ll_still",  2'b00, 1'b1, 2'd0, 3'd4);
        expect_at(232, "ll_run",    2'b11, 1'b0, 2'd1, 3'd0);
        run_to(234);
        pll_lock = 1'b1;
        expect_at(236, "ll_wait",   2'b11, 1'b0, 2'd1, 3'd0);
        expect_at(237, "ll_filter", 2'b11, 1'b0, 2'd1, 3'd1);
        expect_at(253, "ll_hold",   2'b11, 1'b0, 2'd1, 3'd2);
        expect_at(380, "ll_hlast",  2'b11, 1'b0, 2'd1, 3'd2);
        expect_at(381, "ll_rst0",   2'b10, 1'b0, 2'd1, 3'd3);
        expect_at(444, "ll_glast",  2'b10, 1'b0, 2'd1, 3'd3);
        expect_at(445, "ll_run2",   2'b00, 1'b1, 2'd1, 3'd4);
        drain("lock_loss");

        // Soft reset pulse at edge 450
        expect_at(449, "sr_pre",    2'b00, 1'b1, 2'd1, 3'd4);
        run_to(449);
        soft_rst_req = 1'b1;
        expect_at(450, "sr_hit",    2'b11, 1'b0, 2'd1, 3'd2);
        run_to(450);
        soft_rst_req = 1'b0;
        expect_at(481, "sr_hlast",  2'b11, 1'b0, 2'd1, 3'd2);
        expect_at(482, "sr_rst0",   2'b10, 1'b0, 2'd1, 3'd3);
        expect_at(545, "sr_glast",  2'b10, 1'b0, 2'd1, 3'd3);
        expect_at(546, "sr_run",    2'b00, 1'b1, 2'd1, 3'd4);
        drain("soft_pulse");

        // Held request fires once, re-arms after dropping
        run_to(549);
        soft_rst_req = 1'b1;
        expect_at(550, "hd_hit",    2'b11, 1'b0, 2'd1, 3'd2);
        expect_at(582, "hd_rst0",   2'b10, 1'b0, 2'd1, 3'd3);
        expect_at(646, "hd_run",    2'b00, 1'b1, 2'd1, 3'd4);
        expect_at(660, "hd_held",   2'b00, 1'b1, 2'd1, 3'd4);
        run_to(660);
        soft_rst_req = 1'b0;
        run_to(669);
        soft_rst_req = 1'b1;
        expect_at(670, "hd_rearm",  2'b11, 1'b0, 2'd1, 3'd2);
        run_to(670);
        soft_rst_req = 1'b0;

        // Requests in HOLD and RELEASE are ignored and not queued
        run_to(689);
        soft_rst_req = 1'b1;
        expect_at(690, "ig_hold",   2'b11, 1'b0, 2'd1, 3'd2);
        run_to(690);
        soft_rst_req = 1'b0;
        expect_at(701, "ig_hlast",  2'b11, 1'b0, 2'd1, 3'd2);
        expect_at(702, "ig_rst0",   2'b10, 1'b0, 2'd1, 3'd3);
        run_to(719);
        soft_rst_req = 1'b1;
        expect_at(720, "ig_rel",    2'b10, 1'b0, 2'd1, 3'd3);
        run_to(720);
        soft_rst_req = 1'b0;
        expect_at(765, "ig_glast",  2'b10, 1'b0, 2'd1, 3'd3);
        expect_at(766, "ig_run",    2'b00, 1'b1, 2'd1, 3'd4);
        expect_at(770, "ig_noq",    2'b00, 1'b1, 2'd1, 3'd4);
        run_to(770);

        // Lock loss and soft request on the same edge (782)
        run_to(779);
        pll_lock = 1'b0;
        expect_at(781, "sim_pre",   2'b00, 1'b1, 2'd1, 3'd4);
        run_to(781);
        soft_rst_req = 1'b1;
        expect_at(782, "sim_both",  2'b11, 1'b0, 2'd2, 3'd0);
        run_to(782);
        soft_rst_req = 1'b0;
        expect_at(785, "sim_wait",  2'b11, 1'b0, 2'd2, 3'd0);
        run_to(785);

        // Three more losses in HOLD: counter saturates at 3
        cur = 2'd2;
        for (int i = 0; i < 3; i++) begin
            b        = edge_n;
            pll_lock = 1'b1;
            expect_at(b + 19, "sat_hold", 2'b11, 1'b0, cur, 3'd2);
            run_to(b + 20);
            pll_lock = 1'b0;
            nxt = (cur == 2'd3) ? 2'd3 : cur + 2'd1;
            expect_at(b + 23, "sat_loss", 2'b11, 1'b0, nxt, 3'd0);
            run_to(b + 23);
            cur = nxt;
        end
        drain("saturate");

        // Reset mid-RELEASE clears everything at once
        b        = edge_n;
        pll_lock = 1'b1;
        expect_at(b + 147, "mr_rel",  2'b10, 1'b0, 2'd3, 3'd3);
        run_to(b + 150);
        apply_reset("mr_async");
        expect_at(3,   "mr_filter", 2'b11, 1'b0, 2'd0, 3'd1);
        drain("mid_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
